// File: rtl/cmd_framer.sv
// cmd_framer: frames host command bytes into 'P'/'L' packets and releases each packet from a byte FIFO only once it is complete.
// Optional CMD_TIMEOUT_EN aborts a partial packet after TIMEOUT idle cycles.
module cmd_framer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               host_data,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [7:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     pkt_err,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic {IDLE, PARAM} state_t;
  state_t state, state_nx;
  logic [2:0] rem, rem_nx;
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, wr_nx, cm_nx, used;
  logic [7:0] mem [DEPTH];
  logic run, wr_en, err_nx, host_fire, cmd_fire;
`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic expire;
  assign expire = state == PARAM && !host_fire && idle_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (host_fire || state != PARAM || expire) ? '0 : idle_cnt + TW'(1);
`endif
  // used counts uncommitted bytes too, so a stalled packet can never overrun the reader
  assign used       = wr_ptr - rd_ptr;
  assign host_ready = run & ~used[PW-1];
  assign host_fire  = host_valid & host_ready;
  assign cmd_valid  = cm_ptr != rd_ptr;
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign cmd        = cmd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign level      = cm_ptr - rd_ptr;
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    wr_en    = 1'b0;
    cm_nx    = cm_ptr;
    err_nx   = 1'b0;
    wr_nx    = wr_ptr;
    if (host_fire) begin
      if (state == IDLE) begin
        wr_en    = host_data == 8'd80 || host_data == 8'd76;
        err_nx   = !wr_en;
        rem_nx   = host_data == 8'd80 ? 3'd3 : host_data == 8'd76 ? 3'd5 : rem;
        state_nx = wr_en ? PARAM : IDLE;
      end else begin
        wr_en    = 1'b1;
        rem_nx   = rem - 3'd1;
        cm_nx    = rem == 3'd1 ? wr_ptr + PW'(1) : cm_ptr;
        state_nx = rem == 3'd1 ? IDLE : PARAM;
      end
      wr_nx = wr_en ? wr_ptr + PW'(1) : wr_ptr;
    end
`ifdef CMD_TIMEOUT_EN
    else if (expire) begin
      wr_nx    = cm_ptr;
      err_nx   = 1'b1;
      rem_nx   = 3'd0;
      state_nx = IDLE;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      wr_ptr  <= '0;
      cm_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_err <= 1'b0;
      run     <= 1'b0;
    end else begin
      state   <= state_nx;
      rem     <= rem_nx;
      wr_ptr  <= wr_nx;
      cm_ptr  <= cm_nx;
      rd_ptr  <= rd_ptr + PW'(cmd_fire);
      pkt_err <= err_nx;
      run     <= 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= host_data;
endmodule

// File: tb/tb_cmd_framer.sv
// tb_cmd_framer: table-driven and scoreboard checks of cmd_framer packet framing, FIFO backpressure and reset abort.
module tb_cmd_framer;
  localparam int DEPTH = 16;
`ifdef CMD_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 255;
`endif
  logic clk = 1'b0, rst_n = 1'b0, host_valid = 1'b0, cmd_ready = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic host_ready, cmd_valid, pkt_err;
  logic [7:0] cmd;
  logic [$clog2(DEPTH):0] level;
  int n_chk = 0, n_fail = 0, err_seen = 0, exp_err = 0, n_acc = 0;
  logic [7:0] q[$];
  typedef struct {logic [7:0] data; bit keep; bit err;} vec_t;
  vec_t vecs[$];

  cmd_framer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .pkt_err(pkt_err), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard pops on every cmd transfer; idle cmd must read as zero
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (pkt_err) err_seen++;
      if (cmd_valid && cmd_ready) begin
        if (q.size() == 0) check("unexpected_cmd", cmd, -1);
        else check("cmd_byte", cmd, q.pop_front());
      end
      if (!cmd_valid) check("cmd_idle_zero", cmd, 0);
    end
  end

  task automatic send(input logic [7:0] d, input bit keep);
    int t = 0;
    bit ok = 0;
    host_data = d;
    host_valid = 1'b1;
    while (!ok && t < 200) begin
      #1;
      ok = host_ready;
      if (ok) begin
        n_acc++;
        if (keep) q.push_back(d);
      end
      @(negedge clk);
      t++;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int t = 0;
    host_valid = 1'b0;
    cmd_ready = 1'b1;
    while ((q.size() != 0 || cmd_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue", q.size(), 0);
    check("drain_level", level, 0);
  endtask

  initial begin
    vecs = '{'{8'd80, 1, 0}, '{8'd10, 1, 0}, '{8'd20, 1, 0}, '{8'd3, 1, 0},
             '{8'd65, 0, 1}, '{8'd80, 1, 0}, '{8'd5, 1, 0}, '{8'd6, 1, 0}, '{8'd9, 1, 0},
             '{8'd0, 0, 1}, '{8'd76, 1, 0}, '{8'd1, 1, 0}, '{8'd2, 1, 0}, '{8'd3, 1, 0},
             '{8'd4, 1, 0}, '{8'd7, 1, 0}};
    repeat (3) @(negedge clk);
    check("rst_host_ready", host_ready, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_level", level, 0);
    check("rst_pkt_err", pkt_err, 0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", host_ready, 0);
    @(negedge clk);
    check("ready_after_edge", host_ready, 1);

    cmd_ready = 1'b1;
    foreach (vecs[i]) if (i < 4) send(vecs[i].data, vecs[i].keep);
    host_valid = 1'b0;
    check("lat1_valid", cmd_valid, 1);
    check("lat1_opcode", cmd, 80);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("consecutive_valid", cmd_valid, 1);
    end
    @(negedge clk);
    check("after_pkt_valid", cmd_valid, 0);
    check("after_pkt_level", level, 0);

    foreach (vecs[i]) if (i >= 4) begin
      send(vecs[i].data, vecs[i].keep);
      if (vecs[i].err) exp_err++;
    end
    drain();
    check("table_err_count", err_seen, exp_err);

    cmd_ready = 1'b0;
    send(8'd76, 1);
    for (int i = 1; i < 5; i++) send(8'(i), 1);
    send(8'd7, 1);
    host_valid = 1'b0;
    repeat (3) begin
      check("hold_level", level, 6);
      check("hold_valid", cmd_valid, 1);
      check("hold_cmd", cmd, 76);
      @(negedge clk);
    end
    drain();

    cmd_ready = 1'b0;
    n_acc = 0;
    fork
      for (int p = 0; p < 3; p++) begin
        send(8'd76, 1);
        for (int j = 0; j < 5; j++) send(8'(p * 10 + j + 100), 1);
      end
      begin
        repeat (30) @(negedge clk);
        check("full_ready_low", host_ready, 0);
        check("full_accepted", n_acc, 16);
        check("full_level", level, 12);
        cmd_ready = 1'b1;
      end
    join
    drain();

    send(8'd76, 0);
    send(8'd1, 0);
    send(8'd2, 0);
    host_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("async_rst_ready", host_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_level", level, 0);
    send(8'd80, 1);
    for (int i = 1; i < 4; i++) send(8'(i), 1);
    drain();

`ifdef CMD_TIMEOUT_EN
    send(8'd80, 0);
    send(8'd1, 0);
    host_valid = 1'b0;
    exp_err++;
    repeat (10) begin
      @(negedge clk);
      check("timeout_no_valid", cmd_valid, 0);
    end
    check("timeout_err", err_seen, exp_err);
    send(8'd80, 1);
    for (int i = 4; i < 7; i++) send(8'(i), 1);
    drain();
`endif
    repeat (3) @(negedge clk);
    check("final_err_count", err_seen, exp_err);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
